// File: rtl/axis_bits_downsizer.sv
// axis_bits_downsizer: splits wide stream beats into RATIO narrow subwords, LS subword first
module axis_bits_downsizer #(
  parameter int OUT_WIDTH = 32,
  parameter int RATIO     = 2,
  localparam int IN_WIDTH  = OUT_WIDTH * RATIO,
  localparam int CNT_WIDTH = $clog2(RATIO + 1),
  localparam int IDX_W     = $clog2(RATIO)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_tvalid,
  output logic                 in_tready,
  input  logic [IN_WIDTH-1:0]  in_databits,
  input  logic [CNT_WIDTH-1:0] in_count,
  input  logic                 in_tlast,
  output logic                 out_tvalid,
  input  logic                 out_tready,
  output logic [OUT_WIDTH-1:0] out_databits,
  output logic                 out_tlast
);
  logic [IN_WIDTH-1:0]  buf_data_q, buf_data_d;
  logic [CNT_WIDTH-1:0] buf_cnt_q, buf_cnt_d;
  logic                 buf_valid_q, buf_valid_d;
  logic                 buf_last_q, buf_last_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 last_sub, accept, out_hs;
  logic [CNT_WIDTH-1:0] cnt_norm;

  assign last_sub     = CNT_WIDTH'(idx_q) == buf_cnt_q - CNT_WIDTH'(1);
  assign in_tready    = rst_n && (!buf_valid_q || (out_tready && last_sub));
  assign accept       = in_tvalid && in_tready;
  assign out_hs       = buf_valid_q && out_tready;
  assign cnt_norm     = (in_count == '0 || in_count > CNT_WIDTH'(RATIO)) ? CNT_WIDTH'(RATIO) : in_count;
  assign out_tvalid   = buf_valid_q;
  assign out_databits = buf_data_q[idx_q*OUT_WIDTH +: OUT_WIDTH];
  assign out_tlast    = buf_valid_q && buf_last_q && last_sub;

  // Advance through subwords on each output handshake; reload on accept, which may coincide with the last subword
  always_comb begin
    buf_data_d  = buf_data_q;
    buf_cnt_d   = buf_cnt_q;
    buf_last_d  = buf_last_q;
    buf_valid_d = buf_valid_q;
    idx_d       = idx_q;
    if (out_hs) begin
      buf_valid_d = !last_sub;
      idx_d       = last_sub ? '0 : idx_q + IDX_W'(1);
    end
    if (accept) begin
      buf_data_d  = in_databits;
      buf_cnt_d   = cnt_norm;
      buf_last_d  = in_tlast;
      buf_valid_d = 1'b1;
      idx_d       = '0;
    end
  end

  // Holding register state with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_data_q  <= '0;
      buf_cnt_q   <= CNT_WIDTH'(RATIO);
      buf_last_q  <= 1'b0;
      buf_valid_q <= 1'b0;
      idx_q       <= '0;
    end else begin
      buf_data_q  <= buf_data_d;
      buf_cnt_q   <= buf_cnt_d;
      buf_last_q  <= buf_last_d;
      buf_valid_q <= buf_valid_d;
      idx_q       <= idx_d;
    end
  end
endmodule

// File: tb/tb_axis_bits_downsizer.sv
// tb_axis_bits_downsizer: directed checks of the downsizer with OUT_WIDTH=8, RATIO=4
module tb_axis_bits_downsizer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_tvalid = 1'b0;
  logic        in_tready;
  logic [31:0] in_databits = '0;
  logic [2:0]  in_count = '0;
  logic        in_tlast = 1'b0;
  logic        out_tvalid;
  logic        out_tready = 1'b0;
  logic [7:0]  out_databits;
  logic        out_tlast;
  int          n_chk = 0;
  int          n_pass = 0;

  axis_bits_downsizer #(.OUT_WIDTH(8), .RATIO(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_tvalid(in_tvalid), .in_tready(in_tready), .in_databits(in_databits),
    .in_count(in_count), .in_tlast(in_tlast),
    .out_tvalid(out_tvalid), .out_tready(out_tready),
    .out_databits(out_databits), .out_tlast(out_tlast)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] d, input logic [2:0] c, input logic l);
    in_tvalid   = 1'b1;
    in_databits = d;
    in_count    = c;
    in_tlast    = l;
  endtask

  task automatic expo(input string t, input logic [7:0] d, input logic l, input logic r);
    chk({t, ".valid"}, 32'(out_tvalid), 32'd1);
    chk({t, ".data"}, 32'(out_databits), 32'(d));
    chk({t, ".last"}, 32'(out_tlast), 32'(l));
    chk({t, ".ready"}, 32'(in_tready), 32'(r));
  endtask

  task automatic idle(input string t);
    chk({t, ".idle_valid"}, 32'(out_tvalid), 32'd0);
    chk({t, ".idle_last"}, 32'(out_tlast), 32'd0);
  endtask

  initial begin
    step;
    chk("rst.valid", 32'(out_tvalid), 32'd0);
    chk("rst.last", 32'(out_tlast), 32'd0);
    chk("rst.ready", 32'(in_tready), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel.ready", 32'(in_tready), 32'd1);
    out_tready = 1'b1;
    step;
    idle("rel");

    drive(32'h44332211, 3'd4, 1'b1);
    step; in_tvalid = 1'b0;
    expo("full0", 8'h11, 1'b0, 1'b0);
    step; expo("full1", 8'h22, 1'b0, 1'b0);
    step; expo("full2", 8'h33, 1'b0, 1'b0);
    step; expo("full3", 8'h44, 1'b1, 1'b1);
    step; idle("full");

    drive(32'hDDCCBBAA, 3'd4, 1'b0);
    step; drive(32'h44332211, 3'd4, 1'b1);
    expo("b2b0", 8'hAA, 1'b0, 1'b0);
    step; expo("b2b1", 8'hBB, 1'b0, 1'b0);
    step; expo("b2b2", 8'hCC, 1'b0, 1'b0);
    step; expo("b2b3", 8'hDD, 1'b0, 1'b1);
    step; in_tvalid = 1'b0;
    expo("b2b4", 8'h11, 1'b0, 1'b0);
    step; expo("b2b5", 8'h22, 1'b0, 1'b0);
    step; expo("b2b6", 8'h33, 1'b0, 1'b0);
    step; expo("b2b7", 8'h44, 1'b1, 1'b1);
    step; idle("b2b");

    drive(32'h99887766, 3'd2, 1'b1);
    step; drive(32'h0000AA00, 3'd1, 1'b0);
    expo("part0", 8'h66, 1'b0, 1'b0);
    step; expo("part1", 8'h77, 1'b1, 1'b1);
    step; in_tvalid = 1'b0;
    expo("part2", 8'h00, 1'b0, 1'b1);
    step; idle("part");

    drive(32'h44332211, 3'd4, 1'b1);
    step; in_tvalid = 1'b0;
    expo("bp0", 8'h11, 1'b0, 1'b0);
    step; expo("bp1", 8'h22, 1'b0, 1'b0);
    out_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step; expo($sformatf("bp_hold%0d", i), 8'h22, 1'b0, 1'b0);
    end
    out_tready = 1'b1;
    step; expo("bp2", 8'h33, 1'b0, 1'b0);
    step; expo("bp3", 8'h44, 1'b1, 1'b1);
    step; idle("bp");

    drive(32'h0D0C0B0A, 3'd0, 1'b1);
    step; in_tvalid = 1'b0;
    expo("norm0", 8'h0A, 1'b0, 1'b0);
    step; expo("norm1", 8'h0B, 1'b0, 1'b0);
    step; expo("norm2", 8'h0C, 1'b0, 1'b0);
    step; expo("norm3", 8'h0D, 1'b1, 1'b1);
    step; idle("norm");

    drive(32'h44332211, 3'd4, 1'b1);
    step; in_tvalid = 1'b0;
    expo("mid0", 8'h11, 1'b0, 1'b0);
    step; expo("mid1", 8'h22, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid.rst_valid", 32'(out_tvalid), 32'd0);
    chk("mid.rst_ready", 32'(in_tready), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("mid.rel_ready", 32'(in_tready), 32'd1);
    chk("mid.rel_valid", 32'(out_tvalid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step; idle($sformatf("mid_post%0d", i));
      chk($sformatf("mid_post%0d.ready", i), 32'(in_tready), 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/axis_bits_downsizer.md
Name: axis_bits_downsizer

Overview:
- Splits each wide stream beat into RATIO narrow beats, emitted least-significant subword first.
- Supports a partial final beat: the upstream states how many subwords are valid. A flag marks the last subword of a packet.
- Sits between the wide internal DMA datapath and narrower egress stream interfaces, as the width-reducing counterpart to the pipeline slices on those links.

Parameters:
- OUT_WIDTH, 32, width of one output subword in bits (>=1).
- RATIO, 2, subwords per input beat (>=2). Derived: IN_WIDTH = OUT_WIDTH*RATIO; CNT_WIDTH = $clog2(RATIO+1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_tvalid  input  1  input beat valid.
- in_tready  output  1  input beat accepted when in_tvalid && in_tready.
- in_databits  input  IN_WIDTH  input beat; subword k = bits [k*OUT_WIDTH +: OUT_WIDTH].
- in_count  input  CNT_WIDTH  number of valid subwords, 1..RATIO; 0 or >RATIO is treated as RATIO.
- in_tlast  input  1  beat ends a packet.
- out_tvalid  output  1  output subword valid.
- out_tready  input  1  output subword consumed when out_tvalid && out_tready.
- out_databits  output  OUT_WIDTH  current subword.
- out_tlast  output  1  last subword of a packet.

Behaviour:
- State:
  - holding register buf (IN_WIDTH) with buf_valid, buf_cnt (normalised count) and buf_last.
  - subword index idx (0..RATIO-1).
- Reset (rst_n low, asynchronous):
  - buf_valid=0, idx=0.
  - out_tvalid=0, out_tlast=0, in_tready=0 (in_tready is gated by rst_n).
  - buf contents are don't-care.
- Outputs are driven from registers only:
  - out_tvalid = buf_valid.
  - out_databits = buf subword idx.
  - out_tlast = buf_valid && buf_last && (idx == buf_cnt-1).
- last_sub = (idx == buf_cnt-1).
- in_tready = rst_n && (!buf_valid || (out_tready && last_sub)). This is a combinational backward path; there is no combinational forward path from in_* to out_*.
- Accept (in_tvalid && in_tready):
  - buf <= in_databits, buf_cnt <= normalised in_count, buf_last <= in_tlast.
  - buf_valid <= 1, idx <= 0.
  - The first subword appears on the next cycle (latency 1).
- Output handshake when not last_sub: idx <= idx+1.
- Output handshake on last_sub:
  - With a simultaneous accept: reload as above. This gives zero bubbles between beats and 100% output throughput.
  - Otherwise: buf_valid <= 0, idx <= 0.
- Subwords at index >= buf_cnt are never emitted.
- With out_tready low, out_databits, out_tlast, out_tvalid and idx hold stable. in_tready stays 0 while buf_valid.
- Once out_tvalid is asserted, it does not deassert until the handshake completes.
- in_tlast=1 with any count: out_tlast is asserted only on subword buf_cnt-1.
- Reset mid-beat: the partial beat is discarded and no stale subword is emitted after release.
- Upstream protocol: in_databits, in_count and in_tlast must be stable while in_tvalid && !in_tready.

Test Plan:
All cases use OUT_WIDTH=8, RATIO=4.
- Full beat: in_databits=0x44332211, in_count=4, in_tlast=1, out_tready=1.
  - Required: out_databits 0x11,0x22,0x33,0x44 on the 4 cycles after accept.
  - out_tlast=1 only with 0x44.
  - in_tready=0 for the first 3 output cycles, 1 on the 0x44 cycle.
- Back-to-back: 0xDDCCBBAA (count 4, tlast 0) then 0x44332211 (count 4, tlast 1), both presented continuously, out_tready=1.
  - Required: 8 consecutive valid outputs AA,BB,CC,DD,11,22,33,44 with no bubble.
  - out_tlast only on 0x44.
- Partial: 0x99887766, count=2, tlast=1.
  - Required: outputs 0x66 then 0x77 with tlast=1. 0x88/0x99 are never emitted.
  - The next beat 0x0000AA00, count=1, yields the single output 0x00 with out_tlast equal to its tlast.
- Backpressure: during beat 0x44332211, hold out_tready=0 for 3 cycles while 0x22 is presented.
  - Required: out_databits stays 0x22 and out_tvalid stays 1.
  - in_tready=0 throughout; the sequence resumes 0x33,0x44 when out_tready returns high.
- Count normalisation: in_count=0, data 0x0D0C0B0A.
  - Required: 4 outputs 0x0A,0x0B,0x0C,0x0D.
- Reset mid-beat: assert rst_n=0 asynchronously (between edges) after 0x11 is consumed.
  - Required: out_tvalid=0 and in_tready=0 immediately.
  - After release with in_tvalid=0: out_tvalid stays 0 and in_tready rises to 1.
